seg_scan_mux: RTL and testbench

- Parametrised successor to the fixed 4-digit seven-segment time multiplexer.
- Scans NUM_DIGITS digits with a built-in refresh prescaler.
- Adds per-digit enable, PWM brightness, anti-ghosting dead time, selectable output polarity and a frame-start pulse.
- Sits between the digit encoders (one segment pattern per digit) and the board's anode/segment pins.

---
 rtl/seg_scan_pkg.sv | 48 ++++
 rtl/seg_scan_mux_tick_gen.sv | 72 +++++++
 rtl/seg_scan_mux.sv | 107 ++++++++++
 tb/tb_seg_scan_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_pkg
// Brief   : Shared helpers for the seven-segment scan multiplexer: slot
//           sub-division, blank/anode pattern builders, parameter checks.
// Revision: 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  // Widest digit count / segment width the pattern helpers can build.
  localparam int MAX_W = 64;

  // Clocks per brightness phase inside one digit slot.
  function automatic int calc_sub(input int refresh_div, input int bright_w);
    return refresh_div / (1 << bright_w);
  endfunction

  // Segment pattern that lights nothing for the given segment polarity.
  function automatic logic [MAX_W-1:0] blank_pattern(input bit seg_active_low);
    return seg_active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

  // Anode drive: one-hot on bit idx when on=1, all inactive otherwise,
  // then mapped onto the board polarity.
  function automatic logic [MAX_W-1:0] an_drive(input int idx, input bit an_active_low,
                                                input bit on);
    logic [MAX_W-1:0] v;
    v = on ? (MAX_W'(1) << idx) : {MAX_W{1'b0}};
    return an_active_low ? ~v : v;
  endfunction

  // Legal parameter set: slots split evenly into phases, dead time fits
  // inside the first phase, and the pattern helpers are wide enough.
  function automatic bit params_ok(input int num_digits, input int seg_w,
                                   input int refresh_div, input int bright_w,
                                   input int blank_cyc);
    int sub;
    if (num_digits < 2 || num_digits > MAX_W) return 1'b0;
    if (seg_w < 1 || seg_w > MAX_W) return 1'b0;
    if (bright_w < 1 || bright_w > 16) return 1'b0;
    if (refresh_div < 2 || (refresh_div % (1 << bright_w)) != 0) return 1'b0;
    sub = refresh_div / (1 << bright_w);
    if (blank_cyc < 0 || blank_cyc >= sub) return 1'b0;
    return 1'b1;
  endfunction

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/seg_scan_mux_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : scan_tick_gen
// Brief   : Refresh prescaler. Counts clocks within a digit slot and derives
//           the PWM phase plus slot start/end strobes.
// Revision: 1.0 - initial release
// ============================================================================
module scan_tick_gen
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  localparam int CW         = $clog2(REFRESH_DIV)
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [CW-1:0]       cyc_o,
  output logic [BRIGHT_W-1:0] phase_o,
  output logic                slot_start_o,
  output logic                slot_end_o
);

  localparam int SUB = calc_sub(REFRESH_DIV, BRIGHT_W);
  localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam logic [CW-1:0] C_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);

  logic [CW-1:0]       cyc_q,   cyc_d;
  logic [SW-1:0]       sub_q,   sub_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;

  // Phase is tracked with a sub-counter rather than a divider; because the
  // slot is an exact multiple of the phase count, both wrap together.
  always_comb begin
    cyc_d   = cyc_q;
    sub_d   = sub_q;
    phase_d = phase_q;
    if (cyc_q == C_LAST) begin
      cyc_d   = '0;
      sub_d   = '0;
      phase_d = '0;
    end else begin
      cyc_d = cyc_q + CW'(1);
      if (sub_q == SUB_LAST) begin
        sub_d   = '0;
        phase_d = phase_q + BRIGHT_W'(1);
      end else begin
        sub_d = sub_q + SW'(1);
      end
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q   <= '0;
      sub_q   <= '0;
      phase_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      sub_q   <= sub_d;
      phase_q <= phase_d;
    end
  end

  assign cyc_o        = cyc_q;
  assign phase_o      = phase_q;
  assign slot_start_o = (cyc_q == '0);
  assign slot_end_o   = (cyc_q == C_LAST);

endmodule : scan_tick_gen
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_mux
// Brief   : Time-multiplexed seven-segment driver with per-digit enable,
//           PWM brightness, dead time, output polarity and frame pulse.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_W          = 7,
  parameter int REFRESH_DIV    = 100000,
  parameter int BRIGHT_W       = 4,
  parameter int BLANK_CYC      = 2,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            sseg,
  output logic                        frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]    IDX_LAST      = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]    C_BLANK       = CW'(BLANK_CYC);
  localparam logic [MAX_W-1:0] SEG_BLANK_ALL = blank_pattern(SEG_ACTIVE_LOW != 0);
  localparam logic [MAX_W-1:0] AN_OFF_ALL    = an_drive(0, AN_ACTIVE_LOW != 0, 1'b0);
  localparam logic [SEG_W-1:0]      SEG_BLANK = SEG_BLANK_ALL[SEG_W-1:0];
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_OFF_ALL[NUM_DIGITS-1:0];

  if (!params_ok(NUM_DIGITS, SEG_W, REFRESH_DIV, BRIGHT_W, BLANK_CYC)) begin : g_param_check
    $error("seg_scan_mux: illegal parameter combination");
  end

  logic [CW-1:0]       cyc;
  logic [BRIGHT_W-1:0] phase;
  logic                slot_start;
  logic                slot_end;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .BRIGHT_W    (BRIGHT_W)
  ) u_tick (
    .clk          (clk),
    .reset_n      (reset_n),
    .cyc_o        (cyc),
    .phase_o      (phase),
    .slot_start_o (slot_start),
    .slot_end_o   (slot_end)
  );

  logic [IW-1:0]         idx_q,    idx_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic [NUM_DIGITS-1:0] an_q,     an_d;
  logic [SEG_W-1:0]      sseg_q,   sseg_d;
  logic                  fs_q,     fs_d;
  logic [BRIGHT_W-1:0]   bright_eff;
  logic                  active;
  logic [MAX_W-1:0]      an_all;

  // Next digit index, brightness latch and registered drive for (idx, c).
  // At c=0 the freshly presented code is used so the latch and the drive
  // decision agree even when no dead time is configured.
  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    bright_d   = slot_start ? brightness : bright_q;
    bright_eff = bright_d;
    active     = digit_en[idx_q] && (cyc >= C_BLANK) && (phase <= bright_eff);
    an_all     = an_drive(int'(idx_q), AN_ACTIVE_LOW != 0, active);
    an_d       = an_all[NUM_DIGITS-1:0];
    sseg_d     = active ? seg_in[idx_q*SEG_W +: SEG_W] : SEG_BLANK;
    fs_d       = slot_start && (idx_q == '0);
  end

  // Scan state and output registers; reset blanks the display at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      bright_q <= '0;
      an_q     <= AN_OFF;
      sseg_q   <= SEG_BLANK;
      fs_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      bright_q <= bright_d;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = fs_q;

endmodule : seg_scan_mux
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_mux
// Brief   : Self-checking bench for seg_scan_mux (4 digits, 16-clock slots,
//           2-bit brightness, 1 dead-time clock, active-low outputs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

  localparam int ND   = 4;
  localparam int SW   = 7;
  localparam int RD   = 16;
  localparam int BW   = 2;
  localparam int BC   = 1;
  localparam int SUBV = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [ND*SW-1:0] seg_in;
  logic [ND-1:0] digit_en;
  logic [BW-1:0] brightness;
  logic [ND-1:0] an;
  logic [SW-1:0] sseg;
  logic          frame_start;

  seg_scan_mux #(
    .NUM_DIGITS     (ND),
    .SEG_W          (SW),
    .REFRESH_DIV    (RD),
    .BRIGHT_W       (BW),
    .BLANK_CYC      (BC),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .an          (an),
    .sseg        (sseg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [SW-1:0] seg;
    logic          fs;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int m_c, m_idx;
  int m_bright;
  int cyc, last_fs, act_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Predict the output for the model's current (digit, cycle), queue it,
  // clock once, then compare the DUT against the oldest prediction.
  task automatic step();
    exp_t e;
    int   b;
    bit   act;
    b   = (m_c == 0) ? int'(brightness) : m_bright;
    act = digit_en[m_idx] && (m_c >= BC) && ((m_c / SUBV) <= b);
    e.an  = act ? ~(4'b0001 << m_idx) : 4'hF;
    e.seg = act ? seg_in[m_idx*SW +: SW] : 7'h7F;
    e.fs  = (m_idx == 0) && (m_c == 0);
    sb_q.push_back(e);
    if (m_c == 0) m_bright = int'(brightness);
    m_c++;
    if (m_c == RD) begin
      m_c   = 0;
      m_idx = (m_idx + 1) % ND;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (an != 4'hF) act_cnt++;
    if (frame_start) begin
      if (last_fs >= 0) check("frame_period", cyc - last_fs, 64);
      last_fs = cyc;
    end
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("an", {28'h0, an}, {28'h0, e.an});
      check("sseg", {25'h0, sseg}, {25'h0, e.seg});
      check("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
    end
  endtask

  task automatic run_to(input int d);
    int guard;
    guard = 0;
    while (!(m_c == 0 && m_idx == d) && guard < 200) begin
      step();
      guard++;
    end
    check("run_to_reached", (m_c == 0 && m_idx == d) ? 1 : 0, 1);
  endtask

  task automatic slot_duty(input string tag, input int exp_cnt);
    act_cnt = 0;
    repeat (RD) step();
    check(tag, act_cnt, exp_cnt);
  endtask

  initial begin
    reset_n    = 1'b0;
    seg_in     = {7'h30, 7'h12, 7'h24, 7'h40};
    digit_en   = 4'hF;
    brightness = 2'd3;
    m_c = 0; m_idx = 0; m_bright = 0;
    cyc = 0; last_fs = -1; act_cnt = 0;

    // Reset held for five clocks.
    repeat (5) @(posedge clk);
    #1;
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_sseg", {25'h0, sseg}, 32'h7F);
    check("rst_fs", {31'h0, frame_start}, 0);
    reset_n = 1'b1;

    // Full brightness scan: 15 lit clocks per slot, digits in order.
    for (int d = 0; d < ND; d++) slot_duty("duty_full", 15);
    repeat (2) for (int d = 0; d < ND; d++) slot_duty("duty_full_rep", 15);

    // Minimum and low brightness codes.
    brightness = 2'd0;
    slot_duty("duty_b0", 3);
    brightness = 2'd1;
    slot_duty("duty_b1", 7);

    // Digit 2 disabled: its slot stays dark, frame period unchanged.
    brightness = 2'd3;
    digit_en   = 4'b1011;
    run_to(0);
    for (int d = 0; d < ND; d++) slot_duty("duty_en", (d == 2) ? 0 : 15);
    for (int d = 0; d < ND; d++) slot_duty("duty_en_rep", (d == 2) ? 0 : 15);

    // Brightness drop mid-slot of digit 1 only affects digit 2 onward.
    digit_en = 4'hF;
    run_to(1);
    act_cnt = 0;
    repeat (8) step();
    brightness = 2'd0;
    repeat (8) step();
    check("duty_mid_change", act_cnt, 15);
    slot_duty("duty_after_change", 3);

    // Asynchronous reset in the middle of digit 2.
    brightness = 2'd3;
    run_to(2);
    repeat (5) step();
    check("pre_rst_an", {28'h0, an}, 32'hB);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_an", {28'h0, an}, 32'hF);
    check("async_rst_sseg", {25'h0, sseg}, 32'h7F);
    check("async_rst_fs", {31'h0, frame_start}, 0);
    sb_q.delete();
    m_c = 0; m_idx = 0; m_bright = 0; last_fs = -1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", {28'h0, an}, 32'hF);
    reset_n = 1'b1;
    step();
    check("resume_fs", {31'h0, frame_start}, 1);
    repeat (RD - 1) step();
    for (int d = 1; d < ND; d++) slot_duty("duty_resume", 15);
    slot_duty("duty_resume_d0", 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seg_scan_mux
`default_nettype wire
